ethernet_tx_frame: RTL and testbench

//  GMII transmit framer, one per switch port; output counterpart of the 4 per-port rx framers.

---
 rtl/eth_pkg.sv | 29 ++
 rtl/ethernet_tx_frame_crc32.sv | 21 ++
 rtl/ethernet_tx_frame.sv | 117 +++++++++++
 tb/tb_ethernet_tx_frame.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: tx/rx framer state codes, GMII framing constants and the byte-wise Ethernet CRC-32 step.
package eth_pkg;
  localparam logic [2:0] lpND   = 3'd0;
  localparam logic [2:0] lpPRE  = 3'd1;
  localparam logic [2:0] lpSFD  = 3'd2;
  localparam logic [2:0] lpDATA = 3'd3;
  localparam logic [2:0] lpCRC  = 3'd4;
  localparam logic [2:0] lpPAD  = 3'd5;
  localparam logic [2:0] lpIFG  = 3'd6;
  localparam logic [7:0]  lpPRE_BYTE    = 8'h55;
  localparam logic [7:0]  lpSFD_BYTE    = 8'hD5;
  localparam logic [31:0] lpCRC_RESIDUE = 32'hC704DD7B;
  typedef enum logic [2:0] {
    ST_IDLE = lpND,
    ST_PRE  = lpPRE,
    ST_SFD  = lpSFD,
    ST_DATA = lpDATA,
    ST_FCS  = lpCRC,
    ST_PAD  = lpPAD,
    ST_IFG  = lpIFG
  } tx_state_t;
  // Reflected CRC-32 (poly 04C11DB7), data bits LSB first as they go on the wire
  function automatic logic [31:0] eth_crc32_8d(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/ethernet_tx_frame_crc32.sv
// eth_tx_crc32: running FCS register with preset, byte update and complemented byte-select output.
module eth_tx_crc32
  import eth_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_init,
  input  logic       i_en,
  input  logic [7:0] i_data,
  input  logic [1:0] i_sel,
  output logic [7:0] o_fcs
);
  logic [31:0] r_crc;
  logic [31:0] w_inv;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_crc <= '1;
    else if (i_init) r_crc <= '1;
    else if (i_en) r_crc <= eth_crc32_8d(r_crc, i_data);
  assign w_inv = ~r_crc;
  assign o_fcs = w_inv[{i_sel, 3'b000} +: 8];
endmodule

// File: rtl/ethernet_tx_frame.sv
// ethernet_tx_frame: GMII transmit framer adding preamble/SFD, zero pad and FCS, enforcing IFG,
// and turning underrun/oversize/abort into a single TX_ER cycle.
module ethernet_tx_frame
  import eth_pkg::*;
#(
  parameter int PRE_BYTES = 7,
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic       i_tx_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  input  logic       i_abort,
  output logic       o_ready,
  output logic       o_tx_en,
  output logic       o_tx_er,
  output logic [7:0] o_txd,
  output logic [2:0] o_fsm_state,
  output logic       o_frame_done,
  output logic       o_err
);
  localparam logic [10:0] lpMIN      = 11'(MIN_LEN);
  localparam logic [10:0] lpMAX      = 11'(MAX_LEN);
  localparam logic [3:0]  lpPRE_LAST = 4'(PRE_BYTES - 1);
  // The IDLE cycle that samples the next i_valid supplies the final gap cycle on the wire
  localparam logic [3:0]  lpIFG_LAST = 4'(IFG_BYTES - 2);
  tx_state_t   r_state;
  logic [10:0] r_byte_cnt;
  logic [3:0]  r_cnt;
  logic        w_acc;
  logic        w_active;
  logic        w_fail;
  logic [7:0]  w_fcs;
  assign o_ready     = (r_state == ST_DATA) && (r_byte_cnt != lpMAX);
  assign w_acc       = o_ready && i_valid && !i_abort;
  assign w_active    = (r_state == ST_PRE) || (r_state == ST_SFD) || (r_state == ST_DATA) ||
                       (r_state == ST_PAD) || (r_state == ST_FCS);
  assign w_fail      = w_active && (i_abort || ((r_state == ST_DATA) && !w_acc));
  assign o_fsm_state = r_state;
  eth_tx_crc32 u_crc (
    .i_clk  (i_tx_clk),
    .i_rst_n(i_rst_n),
    .i_init (r_state == ST_SFD),
    .i_en   (w_acc || (r_state == ST_PAD)),
    .i_data (w_acc ? i_data : 8'h00),
    .i_sel  (r_cnt[1:0]),
    .o_fcs  (w_fcs)
  );
  always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_byte_cnt   <= '0;
      r_cnt        <= '0;
      o_tx_en      <= 1'b0;
      o_tx_er      <= 1'b0;
      o_txd        <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_tx_en      <= 1'b0;
      o_tx_er      <= 1'b0;
      o_txd        <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      if (w_fail) begin
        o_tx_en <= 1'b1;
        o_tx_er <= 1'b1;
        o_err   <= 1'b1;
        r_cnt   <= '0;
        r_state <= ST_IFG;
      end else begin
        unique case (r_state)
          ST_IDLE: r_state <= i_valid ? ST_PRE : ST_IDLE;
          ST_PRE: begin
            o_tx_en <= 1'b1;
            o_txd   <= lpPRE_BYTE;
            r_cnt   <= r_cnt + 4'd1;
            r_state <= (r_cnt == lpPRE_LAST) ? ST_SFD : ST_PRE;
          end
          ST_SFD: begin
            o_tx_en    <= 1'b1;
            o_txd      <= lpSFD_BYTE;
            r_cnt      <= '0;
            r_byte_cnt <= '0;
            r_state    <= ST_DATA;
          end
          ST_DATA: begin
            o_tx_en    <= 1'b1;
            o_txd      <= i_data;
            r_byte_cnt <= r_byte_cnt + 11'd1;
            r_state    <= !i_last ? ST_DATA : (r_byte_cnt + 11'd1 < lpMIN) ? ST_PAD : ST_FCS;
          end
          ST_PAD: begin
            o_tx_en    <= 1'b1;
            r_byte_cnt <= r_byte_cnt + 11'd1;
            r_state    <= (r_byte_cnt + 11'd1 == lpMIN) ? ST_FCS : ST_PAD;
          end
          ST_FCS: begin
            o_tx_en      <= 1'b1;
            o_txd        <= w_fcs;
            r_cnt        <= (r_cnt == 4'd3) ? 4'd0 : r_cnt + 4'd1;
            o_frame_done <= (r_cnt == 4'd3);
            r_state      <= (r_cnt == 4'd3) ? ST_IFG : ST_FCS;
          end
          ST_IFG: begin
            r_cnt   <= (r_cnt == lpIFG_LAST) ? 4'd0 : r_cnt + 4'd1;
            r_state <= (r_cnt == lpIFG_LAST) ? ST_IDLE : ST_IFG;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ethernet_tx_frame.sv
// tb_ethernet_tx_frame: directed-plus-random bench; expected wire bytes come from a frame-level model.
module tb_ethernet_tx_frame;
  import eth_pkg::*;
  typedef logic [8:0] q9_t[$];
  typedef logic [7:0] q8_t[$];
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = '0;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic       abort = 1'b0;
  logic       ready, tx_en, tx_er, done, err;
  logic [7:0] txd;
  logic [2:0] fsm;
  logic [7:0] pl[2][1600];
  logic [8:0] cap[8][1600];
  int cap_len[8];
  int cap_gap[8];
  int nfr = 0, cur = 0, idle_run = 0, n_done = 0, n_err = 0;
  int n_cmp = 0, n_bad = 0;
  int ex_done = 0, ex_err = 0, acc, t, f0;
  int lens[3];

  ethernet_tx_frame dut (
    .i_tx_clk    (clk),
    .i_rst_n     (rst_n),
    .i_data      (data),
    .i_valid     (valid),
    .i_last      (last),
    .i_abort     (abort),
    .o_ready     (ready),
    .o_tx_en     (tx_en),
    .o_tx_er     (tx_er),
    .o_txd       (txd),
    .o_fsm_state (fsm),
    .o_frame_done(done),
    .o_err       (err)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur = 0;
      idle_run = 0;
    end else begin
      if (done) n_done++;
      if (err) n_err++;
      if (tx_en) begin
        if (cur == 0) cap_gap[nfr % 8] = idle_run;
        if (cur < 1600) cap[nfr % 8][cur] = {tx_er, txd};
        cur++;
        idle_run = 0;
      end else begin
        if (cur != 0) begin
          cap_len[nfr % 8] = cur;
          nfr++;
          cur = 0;
        end
        idle_run++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Non-reflected CRC-32 over wire bit order; a good frame+FCS leaves the residue constant
  function automatic logic [31:0] crc_nr(input q8_t q);
    logic [31:0] c;
    c = '1;
    foreach (q[j]) for (int i = 0; i < 8; i++)
      c = {c[30:0], 1'b0} ^ ((c[31] ^ q[j][i]) ? 32'h04C11DB7 : 32'h0);
    return c;
  endfunction

  function automatic q9_t exp_hdr();
    q9_t e;
    for (int i = 0; i < 7; i++) e.push_back({1'b0, 8'h55});
    e.push_back({1'b0, 8'hD5});
    return e;
  endfunction

  function automatic q9_t exp_clean(input int k, input int n);
    q9_t e;
    q8_t p;
    logic [31:0] r;
    e = exp_hdr();
    for (int i = 0; i < n; i++) p.push_back(pl[k][i]);
    while (p.size() < 60) p.push_back(8'h00);
    r = crc_nr(p);
    r = ~{<<{r}};
    for (int i = 0; i < 4; i++) p.push_back(r[8*i +: 8]);
    foreach (p[j]) e.push_back({1'b0, p[j]});
    return e;
  endfunction

  function automatic q9_t exp_err(input int k, input int a);
    q9_t e;
    e = exp_hdr();
    for (int i = 0; i < a; i++) e.push_back({1'b0, pl[k][i]});
    e.push_back(9'h100);
    return e;
  endfunction

  task automatic check_frame(input int f, input q9_t e, input string tag);
    int bad;
    bad = 0;
    chk({tag, " len"}, cap_len[f % 8], e.size());
    for (int i = 0; i < e.size() && i < cap_len[f % 8]; i++)
      if (cap[f % 8][i] !== e[i]) bad++;
    chk({tag, " bytes"}, bad, 0);
  endtask

  task automatic residue(input int f, input string tag);
    q8_t q;
    for (int i = 8; i < cap_len[f % 8]; i++) q.push_back(cap[f % 8][i][7:0]);
    chk({tag, " residue"}, crc_nr(q), lpCRC_RESIDUE);
  endtask

  task automatic wait_frames(input int target);
    int tt;
    tt = 0;
    while (nfr < target && tt < 5000) begin
      @(posedge clk);
      tt++;
    end
    chk("frame wait timeout", nfr >= target, 1);
  endtask

  task automatic send(input int k, input int n, input bit use_last, input int stop_at,
                      input bit stop_abort, input bit keep, output int accepted);
    int i, tt;
    bit hs, rdy, seen;
    i = 0; tt = 0; seen = 0;
    valid = 1; data = pl[k][0]; last = use_last && n == 1; abort = 0;
    while (i < n && tt < 5000) begin
      if (i == stop_at) begin
        if (stop_abort) begin abort = 1; last = 1; end
        else valid = 0;
        @(posedge clk); #1;
        break;
      end
      @(negedge clk);
      hs = valid && ready;
      rdy = ready;
      @(posedge clk); #1;
      tt++;
      if (rdy) seen = 1;
      if (hs) begin
        i++;
        if (i < n) begin
          data = pl[k][i];
          last = use_last && i == n - 1;
        end
      end else if (seen) break;
    end
    if (!(keep && i == n)) begin valid = 0; last = 0; abort = 0; end
    accepted = i;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset tx_en", tx_en, 0);
    chk("reset tx_er", tx_er, 0);
    chk("reset txd", txd, 0);
    chk("reset ready", ready, 0);
    chk("reset fsm", fsm, lpND);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(posedge clk); #1;

    // 60-byte counting frame: no padding
    for (int i = 0; i < 60; i++) pl[0][i] = 8'(i);
    f0 = nfr;
    send(0, 60, 1, -1, 0, 0, acc);
    wait_frames(f0 + 1);
    check_frame(f0, exp_clean(0, 60), "f60");
    residue(f0, "f60");
    ex_done++;
    chk("f60 done", n_done, ex_done);
    chk("f60 err", n_err, ex_err);

    // 14-byte frame: 46 pad bytes covered by FCS
    for (int i = 0; i < 14; i++) pl[0][i] = 8'($urandom);
    f0 = nfr;
    send(0, 14, 1, -1, 0, 0, acc);
    chk("f14 in pad", fsm, lpPAD);
    wait_frames(f0 + 1);
    check_frame(f0, exp_clean(0, 14), "f14");
    residue(f0, "f14");
    ex_done++;

    // pad boundary and a random length
    lens[0] = 59; lens[1] = 61; lens[2] = int'($urandom_range(1, 150));
    foreach (lens[j]) begin
      for (int i = 0; i < lens[j]; i++) pl[0][i] = 8'($urandom);
      f0 = nfr;
      send(0, lens[j], 1, -1, 0, 0, acc);
      wait_frames(f0 + 1);
      check_frame(f0, exp_clean(0, lens[j]), $sformatf("len%0d", lens[j]));
      ex_done++;
    end
    chk("random done", n_done, ex_done);

    // back-to-back 64-byte frames with valid held high
    for (int i = 0; i < 64; i++) begin pl[0][i] = 8'($urandom); pl[1][i] = 8'($urandom); end
    f0 = nfr;
    send(0, 64, 1, -1, 0, 1, acc);
    send(1, 64, 1, -1, 0, 0, acc);
    wait_frames(f0 + 2);
    check_frame(f0, exp_clean(0, 64), "b2b0");
    check_frame(f0 + 1, exp_clean(1, 64), "b2b1");
    chk("b2b gap", cap_gap[(f0 + 1) % 8], 12);
    ex_done += 2;
    chk("b2b done", n_done, ex_done);

    // underrun at byte 20, next frame requested immediately
    for (int i = 0; i < 60; i++) begin pl[0][i] = 8'($urandom); pl[1][i] = 8'($urandom); end
    f0 = nfr;
    send(0, 60, 1, 20, 0, 0, acc);
    send(1, 30, 1, -1, 0, 0, acc);
    wait_frames(f0 + 2);
    check_frame(f0, exp_err(0, 20), "underrun");
    check_frame(f0 + 1, exp_clean(1, 30), "after underrun");
    chk("underrun gap", cap_gap[(f0 + 1) % 8], 12);
    ex_err++; ex_done++;
    chk("underrun err", n_err, ex_err);
    chk("underrun done", n_done, ex_done);

    // i_last together with i_abort: abort wins
    for (int i = 0; i < 31; i++) pl[0][i] = 8'($urandom);
    f0 = nfr;
    send(0, 31, 1, 30, 1, 0, acc);
    wait_frames(f0 + 1);
    check_frame(f0, exp_err(0, 30), "abort");
    ex_err++;
    chk("abort err", n_err, ex_err);
    chk("abort done", n_done, ex_done);

    // oversize: 1600-byte stream with no i_last
    for (int i = 0; i < 1600; i++) pl[0][i] = 8'($urandom);
    f0 = nfr;
    send(0, 1600, 0, -1, 0, 0, acc);
    chk("oversize accepted", acc, 1514);
    wait_frames(f0 + 1);
    check_frame(f0, exp_err(0, 1514), "oversize");
    ex_err++;
    chk("oversize err", n_err, ex_err);

    // async reset during FCS byte 2, then a clean restart
    for (int i = 0; i < 60; i++) pl[0][i] = 8'($urandom);
    f0 = nfr;
    send(0, 60, 1, -1, 0, 0, acc);
    t = 0;
    while (cur != 70 && t < 500) begin @(posedge clk); #2; t++; end
    chk("pre-reset tx_en", tx_en, 1);
    rst_n = 0;
    #1;
    chk("async rst tx_en", tx_en, 0);
    chk("async rst tx_er", tx_er, 0);
    chk("async rst txd", txd, 0);
    chk("async rst fsm", fsm, lpND);
    repeat (2) @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    chk("reset frame dropped", nfr, f0);
    for (int i = 0; i < 40; i++) pl[0][i] = 8'($urandom);
    send(0, 40, 1, -1, 0, 0, acc);
    wait_frames(f0 + 1);
    check_frame(f0, exp_clean(0, 40), "post-reset");
    residue(f0, "post-reset");
    ex_done++;
    chk("final done", n_done, ex_done);
    chk("final err", n_err, ex_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
